// File: rtl/timer_display.sv
// Converts the countdown's binary mm:ss into four active-low seven-segment digits
// using a shared-timing shift-add-3 engine, and blinks the display while expired.
module timer_display #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BLINK_HZ = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       rem,
  output logic [6:0] hex_m1,
  output logic [6:0] hex_m0,
  output logic [6:0] hex_s1,
  output logic [6:0] hex_s0,
  output logic       busy
);

  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [BW-1:0] HALF_M1 = BW'(HALF - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // One double-dabble step: correct both nibbles, then shift the next binary bit in.
  function automatic logic [7:0] bcd_step(input logic [7:0] bcd, input logic msb);
    logic [7:0] adj;
    adj = {add3(bcd[7:4]), add3(bcd[3:0])};
    return (adj << 1) | {7'd0, msb};
  endfunction

  state_t        state_q, state_d;
  logic [11:0]   last_q, last_d;
  logic [5:0]    m_shift_q, m_shift_d, s_shift_q, s_shift_d;
  logic [7:0]    m_bcd_q, m_bcd_d, s_bcd_q, s_bcd_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [3:0]    dig_m1_q, dig_m1_d, dig_m0_q, dig_m0_d;
  logic [3:0]    dig_s1_q, dig_s1_d, dig_s0_q, dig_s0_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [6:0]    hex_m1_q, hex_m1_d, hex_m0_q, hex_m0_d;
  logic [6:0]    hex_s1_q, hex_s1_d, hex_s0_q, hex_s0_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    m_shift_d = m_shift_q;
    s_shift_d = s_shift_q;
    m_bcd_d   = m_bcd_q;
    s_bcd_d   = s_bcd_q;
    cnt_d     = cnt_q;
    dig_m1_d  = dig_m1_q;
    dig_m0_d  = dig_m0_q;
    dig_s1_d  = dig_s1_q;
    dig_s0_d  = dig_s0_q;
    case (state_q)
      S_IDLE: begin
        if ({minutes, seconds} != last_q) begin
          last_d    = {minutes, seconds};
          m_shift_d = minutes;
          s_shift_d = seconds;
          m_bcd_d   = 8'd0;
          s_bcd_d   = 8'd0;
          cnt_d     = 3'd0;
          state_d   = S_CONV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        m_bcd_d   = bcd_step(m_bcd_q, m_shift_q[5]);
        s_bcd_d   = bcd_step(s_bcd_q, s_shift_q[5]);
        m_shift_d = {m_shift_q[4:0], 1'b0};
        s_shift_d = {s_shift_q[4:0], 1'b0};
        cnt_d     = cnt_q + 3'd1;
        if (cnt_q == 3'd5) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_CONV;
        end
      end
      S_LOAD: begin
        dig_m1_d = m_bcd_q[7:4];
        dig_m0_d = m_bcd_q[3:0];
        dig_s1_d = s_bcd_q[7:4];
        dig_s0_d = s_bcd_q[3:0];
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Blink timebase runs only while expired; phase 1 blanks every digit.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (rem) begin
      if (blink_cnt_q == HALF_M1) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        phase_d     = phase_q;
      end
    end else begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end
  end

  // Outputs are registered from next-state so they change on the same edge as their source.
  always_comb begin
    hex_m1_d = phase_d ? SEG_BLANK : seg7(dig_m1_d);
    hex_m0_d = phase_d ? SEG_BLANK : seg7(dig_m0_d);
    hex_s1_d = phase_d ? SEG_BLANK : seg7(dig_s1_d);
    hex_s0_d = phase_d ? SEG_BLANK : seg7(dig_s0_d);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      last_q      <= 12'd0;
      m_shift_q   <= 6'd0;
      s_shift_q   <= 6'd0;
      m_bcd_q     <= 8'd0;
      s_bcd_q     <= 8'd0;
      cnt_q       <= 3'd0;
      dig_m1_q    <= 4'd0;
      dig_m0_q    <= 4'd0;
      dig_s1_q    <= 4'd0;
      dig_s0_q    <= 4'd0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      hex_m1_q    <= SEG_ZERO;
      hex_m0_q    <= SEG_ZERO;
      hex_s1_q    <= SEG_ZERO;
      hex_s0_q    <= SEG_ZERO;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      m_shift_q   <= m_shift_d;
      s_shift_q   <= s_shift_d;
      m_bcd_q     <= m_bcd_d;
      s_bcd_q     <= s_bcd_d;
      cnt_q       <= cnt_d;
      dig_m1_q    <= dig_m1_d;
      dig_m0_q    <= dig_m0_d;
      dig_s1_q    <= dig_s1_d;
      dig_s0_q    <= dig_s0_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      hex_m1_q    <= hex_m1_d;
      hex_m0_q    <= hex_m0_d;
      hex_s1_q    <= hex_s1_d;
      hex_s0_q    <= hex_s0_d;
      busy_q      <= busy_d;
    end
  end

  assign hex_m1 = hex_m1_q;
  assign hex_m0 = hex_m0_q;
  assign hex_s1 = hex_s1_q;
  assign hex_s0 = hex_s0_q;
  assign busy   = busy_q;

endmodule

// File: doc/timer_display.md
# timer_display

Drives four active-low seven-segment digits from the binary `minutes`/`seconds`/`rem` outputs of the quiz countdown timer. This block is the consumer end of that interface. It detects value changes and converts each 6-bit field to two BCD digits with a sequential shift-add-3 engine. It blinks the whole display once the timer reports expiry. It sits between the countdown and the board HEX pins.

## Interface
- `CLK_HZ`, default 50_000_000: clock frequency in Hz.
- `BLINK_HZ`, default 2: full blink cycles per second while expired. Half-period `HALF = CLK_HZ/(2*BLINK_HZ)` cycles; `HALF >= 2` is required.
- `clk`  input  1: system clock. All logic is on the rising edge.
- `reset`  input  1: synchronous, active-low reset.
- `minutes`  input  6: remaining minutes, binary, 0..63.
- `seconds`  input  6: remaining seconds, binary, 0..63.
- `rem`  input  1: timer expired flag (level).
- `hex_m1`  output  7: minutes tens digit. Segments {g,f,e,d,c,b,a}, active-low.
- `hex_m0`  output  7: minutes units digit.
- `hex_s1`  output  7: seconds tens digit.
- `hex_s0`  output  7: seconds units digit.
- `busy`  output  1: high while a conversion is in flight.

## Operation
- Registers:
  - `last` (12 bits): value being or last displayed.
  - Two shift/BCD working sets, one for minutes and one for seconds.
  - 3-bit shift counter.
  - Four 4-bit digit registers.
  - Blink counter and blink phase bit.
  - 2-bit state.
- States: IDLE, CONV, LOAD.
- IDLE:
  - If `{minutes,seconds} != last`: capture the inputs into `last` and both shift registers, clear the BCD accumulators, set the counter to 0, go to CONV.
  - Otherwise stay in IDLE.
- CONV:
  - Each cycle, for both fields in parallel: add 3 to any BCD nibble >= 5, then shift left one bit (MSB of the binary field into the BCD LSB).
  - Exactly 6 cycles. After the 6th, go to LOAD.
- LOAD:
  - Write the four BCD nibbles to the digit registers.
  - Go to IDLE.
- Input changes during CONV/LOAD are ignored. The IDLE re-compare guarantees the latest value is displayed eventually.
- Range: values 60..63 display literally (e.g. 63 -> "6","3"). No clamping and no leading-zero blanking.
- Segment map (active-low, `{g..a}`):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Digit values above 9 cannot occur.
- Blink:
  - While `rem`=1, the blink counter counts 0..HALF-1. On wrap, the phase toggles.
  - Phase 1 forces all four outputs to 1111111 (blank).
  - While `rem`=0, the counter and phase are held at 0 and the display is always lit.
  - The first blank occurs HALF cycles after `rem` rises.
- `busy` = (state != IDLE).

## Timing
- Reset (`reset`=0 at an edge):
  - state=IDLE, `last`=0, digit regs=0, blink counter=0, phase=0.
  - Outputs: all hex = 1000000 ("00:00"), `busy`=0.
  - Reset mid-conversion aborts the conversion; no partial digit is ever shown.
- Change-to-display latency, for a new value present before edge k while IDLE:
  - Edge k captures the value; `busy`=1 after k.
  - Edges k+1..k+6 run CONV; edge k+7 runs LOAD.
  - Digits change and `busy`=0 after edge k+7, i.e. 7 cycles.
- Back-to-back: a new value that differs from `last` and is present at the edge LOAD leaves is captured on the following IDLE edge. Minimum spacing between display updates is 8 cycles.
- Simultaneous `rem` rise and value change: both proceed independently. Blanking overrides digit content in the same cycle the phase becomes 1.
- Blink and conversion are independent. A LOAD during the blank phase updates the digit registers, and the new digits show when the phase returns to 0.

## Test plan
- Reset with inputs 0:00: hold `reset`=0 for 2 cycles, release -> all hex=1000000 and `busy`=0 indefinitely; no conversion starts.
- Apply minutes=3, seconds=0 at edge k -> `busy`=1 for edges k..k+6; after k+7, hex_m1=1000000, hex_m0=0110000, hex_s1=hex_s0=1000000.
- Step seconds 59 down to 0 (minutes=2), one change every 20 cycles -> after each change, outputs match the decimal value 7 cycles later. Check 2:59 -> hex_s1=0010010, hex_s0=0010000.
- Change input at k, then again at k+3 (mid-CONV) -> the first value is displayed after k+7; the second value is captured at k+8 and displayed after k+15.
- Max value 63:63 -> hex_m1=hex_s1=0000010 and hex_m0=hex_s0=0110000.
- With CLK_HZ=40, BLINK_HZ=2 (HALF=10): raise `rem` with 0:00 shown -> lit for 10 cycles, blank for 10, lit for 10. Drop `rem` -> display lit within 1 cycle. Pull `reset` low mid-blank -> "00:00" lit after the reset edge.
